// File: rtl/stopwatch_timer_if.sv
// Command, preload and display bundle between the stopwatch core and its controller/display path.
// The controller side uses modport master; the timer core uses modport slave.
interface stopwatch_timer_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       load;
  logic       dir;
  logic       lap;
  logic [3:0] load_min_tens, load_min_ones, load_sec_tens, load_sec_ones, load_hund_tens, load_hund_ones;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, hund_tens, hund_ones;
  logic       running;
  logic       done;
  logic       wrap;

  modport master (
    output start, stop, clear, load, dir, lap,
    output load_min_tens, load_min_ones, load_sec_tens, load_sec_ones, load_hund_tens, load_hund_ones,
    input  min_tens, min_ones, sec_tens, sec_ones, hund_tens, hund_ones,
    input  running, done, wrap
  );

  modport slave (
    input  start, stop, clear, load, dir, lap,
    input  load_min_tens, load_min_ones, load_sec_tens, load_sec_ones, load_hund_tens, load_hund_ones,
    output min_tens, min_ones, sec_tens, sec_ones, hund_tens, hund_ones,
    output running, done, wrap
  );
endinterface

// File: rtl/stopwatch_timer.sv
// Up/down BCD stopwatch in hundredths of a second with preload, lap-hold display and done/wrap pulses.
// Optional STOPWATCH_MINUTES_EN extends the digit chain with two minute digits (max 99:59.99).
module stopwatch_timer #(
  parameter int unsigned TICK_DIV = 500000,
  parameter bit          WRAP     = 1'b1
) (
  input logic              clk,
  input logic              rst,
  stopwatch_timer_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] hund_tens;
    logic [3:0] hund_ones;
  } digits_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  digits_t       live, live_nx, disp, inc_val, dec_val, load_val;
  logic          done_q, done_nx, wrap_q, wrap_nx;
  logic          tick, live_zero, live_max, min_at_max, cy, bw;

  // Returns {carry_out, digit}: a digit at its limit rolls to 0 and carries.
  function automatic logic [4:0] step_up(input logic [3:0] v, input logic [3:0] lim, input logic cin);
    if (!cin)     return {1'b0, v};
    if (v >= lim) return {1'b1, 4'd0};
    return {1'b0, v + 4'd1};
  endfunction

  function automatic logic [4:0] step_dn(input logic [3:0] v, input logic [3:0] lim, input logic bin);
    if (!bin)       return {1'b0, v};
    if (v == 4'd0)  return {1'b1, lim};
    return {1'b0, v - 4'd1};
  endfunction

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

`ifdef STOPWATCH_MINUTES_EN
  assign min_at_max = (live.min_tens == 4'd9) && (live.min_ones == 4'd9);
`else
  logic unused_min_load;
  assign unused_min_load = ^{bus.load_min_tens, bus.load_min_ones};
  assign min_at_max      = 1'b1;
`endif

  assign tick      = (state == S_RUN) && (presc == PW'(TICK_DIV - 1));
  assign live_zero = (live == '0);
  assign live_max  = min_at_max && (live.sec_tens == 4'd5) && (live.sec_ones == 4'd9) &&
                     (live.hund_tens == 4'd9) && (live.hund_ones == 4'd9);

  always_comb begin
    inc_val = live;
    dec_val = live;
    cy      = 1'b1;
    bw      = 1'b1;
    {cy, inc_val.hund_ones} = step_up(live.hund_ones, 4'd9, cy);
    {cy, inc_val.hund_tens} = step_up(live.hund_tens, 4'd9, cy);
    {cy, inc_val.sec_ones}  = step_up(live.sec_ones,  4'd9, cy);
    {cy, inc_val.sec_tens}  = step_up(live.sec_tens,  4'd5, cy);
    {bw, dec_val.hund_ones} = step_dn(live.hund_ones, 4'd9, bw);
    {bw, dec_val.hund_tens} = step_dn(live.hund_tens, 4'd9, bw);
    {bw, dec_val.sec_ones}  = step_dn(live.sec_ones,  4'd9, bw);
    {bw, dec_val.sec_tens}  = step_dn(live.sec_tens,  4'd5, bw);
`ifdef STOPWATCH_MINUTES_EN
    {cy, inc_val.min_ones}  = step_up(live.min_ones,  4'd9, cy);
    {cy, inc_val.min_tens}  = step_up(live.min_tens,  4'd9, cy);
    {bw, dec_val.min_ones}  = step_dn(live.min_ones,  4'd9, bw);
    {bw, dec_val.min_tens}  = step_dn(live.min_tens,  4'd9, bw);
`endif
  end

  always_comb begin
    load_val.hund_ones = clamp(bus.load_hund_ones, 4'd9);
    load_val.hund_tens = clamp(bus.load_hund_tens, 4'd9);
    load_val.sec_ones  = clamp(bus.load_sec_ones,  4'd9);
    load_val.sec_tens  = clamp(bus.load_sec_tens,  4'd5);
`ifdef STOPWATCH_MINUTES_EN
    load_val.min_ones  = clamp(bus.load_min_ones,  4'd9);
    load_val.min_tens  = clamp(bus.load_min_tens,  4'd9);
`else
    load_val.min_ones  = 4'd0;
    load_val.min_tens  = 4'd0;
`endif
  end

  // Command priority below the reset: clear > load > stop > start.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nx = state;
    presc_nx = presc;
    live_nx  = live;
    done_nx  = 1'b0;
    wrap_nx  = 1'b0;
    if (bus.clear) begin
      state_nx = S_IDLE;
      presc_nx = '0;
      live_nx  = '0;
    end else if (bus.load && state != S_RUN) begin
      state_nx = S_IDLE;
      presc_nx = '0;
      live_nx  = load_val;
    end else if (state == S_RUN) begin
      presc_nx = tick ? '0 : presc + 1'b1;
      if (tick && !bus.dir) begin
        if (!live_max) begin
          live_nx = inc_val;
        end else if (WRAP) begin
          live_nx = '0;
          wrap_nx = 1'b1;
        end else begin
          done_nx  = 1'b1;
          state_nx = S_DONE;
        end
      end else if (tick) begin
        // A zero value never underflows; reaching (or sitting at) zero finishes the countdown.
        live_nx  = live_zero ? live : dec_val;
        if (live_zero || dec_val == '0) begin
          done_nx  = 1'b1;
          state_nx = S_DONE;
        end
      end
      if (bus.stop && state_nx == S_RUN) state_nx = S_PAUSE;
    end else if (bus.start && !bus.stop && state != S_DONE && !(bus.dir && live_zero)) begin
      state_nx = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; rst only takes effect on a rising clk edge.
    if (rst) begin
      state  <= S_IDLE;
      presc  <= '0;
      live   <= '0;
      disp   <= '0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state  <= state_nx;
      presc  <= presc_nx;
      live   <= live_nx;
      done_q <= done_nx;
      wrap_q <= wrap_nx;
      if (bus.clear)    disp <= '0;
      else if (!bus.lap) disp <= live;
    end
  end

  assign bus.min_tens  = disp.min_tens;
  assign bus.min_ones  = disp.min_ones;
  assign bus.sec_tens  = disp.sec_tens;
  assign bus.sec_ones  = disp.sec_ones;
  assign bus.hund_tens = disp.hund_tens;
  assign bus.hund_ones = disp.hund_ones;
  assign bus.running   = (state == S_RUN);
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Bench for stopwatch_timer: directed scenarios plus randomized commands against a centisecond-count model.
// dut0 wraps at max (WRAP=1); dut1 saturates (WRAP=0) and shares dut0's inputs.
module tb_stopwatch_timer;
  localparam int TD = 4;
`ifdef STOPWATCH_MINUTES_EN
  localparam bit MIN_EN = 1'b1;
  localparam int MAXV   = 99 * 6000 + 5999;
`else
  localparam bit MIN_EN = 1'b0;
  localparam int MAXV   = 5999;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  stopwatch_timer_if sw0 ();
  stopwatch_timer_if sw1 ();

  stopwatch_timer #(.TICK_DIV(TD), .WRAP(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(sw0.slave));
  stopwatch_timer #(.TICK_DIV(TD), .WRAP(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(sw1.slave));

  assign sw1.start          = sw0.start;
  assign sw1.stop           = sw0.stop;
  assign sw1.clear          = sw0.clear;
  assign sw1.load           = sw0.load;
  assign sw1.dir            = sw0.dir;
  assign sw1.lap            = sw0.lap;
  assign sw1.load_min_tens  = sw0.load_min_tens;
  assign sw1.load_min_ones  = sw0.load_min_ones;
  assign sw1.load_sec_tens  = sw0.load_sec_tens;
  assign sw1.load_sec_ones  = sw0.load_sec_ones;
  assign sw1.load_hund_tens = sw0.load_hund_tens;
  assign sw1.load_hund_ones = sw0.load_hund_ones;

  // Reference model: the live value is a plain count of hundredths of a second.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_presc = 0;
  int      m_cnt   = 0;
  int      m_disp  = 0;
  logic    m_done  = 1'b0;
  logic    m_wrap  = 1'b0;

  function automatic int clampd(input logic [3:0] d, input int lim);
    return (int'(d) > lim) ? lim : int'(d);
  endfunction

  function automatic int load_value();
    int mins;
    mins = MIN_EN ? clampd(sw0.load_min_tens, 9) * 10 + clampd(sw0.load_min_ones, 9) : 0;
    return mins * 6000 + (clampd(sw0.load_sec_tens, 5) * 10 + clampd(sw0.load_sec_ones, 9)) * 100 +
           clampd(sw0.load_hund_tens, 9) * 10 + clampd(sw0.load_hund_ones, 9);
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    int m, s, h;
    m = v / 6000;
    s = (v / 100) % 60;
    h = v % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  function automatic logic [23:0] shown0();
    return {sw0.min_tens, sw0.min_ones, sw0.sec_tens, sw0.sec_ones, sw0.hund_tens, sw0.hund_ones};
  endfunction

  function automatic logic [23:0] shown1();
    return {sw1.min_tens, sw1.min_ones, sw1.sec_tens, sw1.sec_ones, sw1.hund_tens, sw1.hund_ones};
  endfunction

  always @(posedge clk) begin : ref_model
    mstate_t s;
    int      p, c;
    logic    dn, wr;
    s = m_state; p = m_presc; c = m_cnt; dn = 1'b0; wr = 1'b0;
    if (rst || sw0.clear) begin
      s = M_IDLE; p = 0; c = 0;
    end else if (sw0.load && s != M_RUN) begin
      s = M_IDLE; p = 0; c = load_value();
    end else if (s == M_RUN) begin
      if (p == TD - 1) begin
        p = 0;
        if (!sw0.dir) begin
          if (c == MAXV) begin c = 0; wr = 1'b1; end
          else c = c + 1;
        end else begin
          if (c > 0) c = c - 1;
          if (c == 0) begin dn = 1'b1; s = M_DONE; end
        end
      end else begin
        p = p + 1;
      end
      if (sw0.stop && s == M_RUN) s = M_PAUSE;
    end else if (sw0.start && !sw0.stop && s != M_DONE && !(sw0.dir && c == 0)) begin
      s = M_RUN;
    end
    m_disp  <= (rst || sw0.clear) ? 0 : (sw0.lap ? m_disp : m_cnt);
    m_state <= s;
    m_presc <= p;
    m_cnt   <= c;
    m_done  <= dn;
    m_wrap  <= wr;
  end

  task automatic tick_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    sw0.start = 1'b1; @(negedge clk); sw0.start = 1'b0;
  endtask

  task automatic do_stop();
    sw0.stop = 1'b1; @(negedge clk); sw0.stop = 1'b0;
  endtask

  task automatic do_clear();
    sw0.clear = 1'b1; @(negedge clk); sw0.clear = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] mt, mo, st, so, ht, ho);
    sw0.load_min_tens = mt; sw0.load_min_ones = mo; sw0.load_sec_tens = st;
    sw0.load_sec_ones = so; sw0.load_hund_tens = ht; sw0.load_hund_ones = ho;
    sw0.load = 1'b1; @(negedge clk); sw0.load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick_clk(3);
    n_checks++; if (shown0() !== 24'h0) begin n_fail++; $display("FAIL reset_disp: got %h want %h", shown0(), 24'h0); end
    n_checks++; if (sw0.running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", sw0.running); end
    n_checks++; if (sw0.done !== 1'b0 || sw0.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b wrap=%b want 0/0", sw0.done, sw0.wrap); end
    n_checks++; if (shown1() !== 24'h0 || sw1.running !== 1'b0) begin n_fail++; $display("FAIL reset_dut1: got %h run=%b want 000000 run=0", shown1(), sw1.running); end
    rst = 1'b0;
  endtask

  task automatic test_count_up();
    sw0.dir = 1'b0;
    do_start();
    tick_clk(400);
    n_checks++; if (shown0() !== 24'h000099) begin n_fail++; $display("FAIL up_before_100th: got %h want %h", shown0(), 24'h000099); end
    tick_clk(1);
    n_checks++; if (shown0() !== 24'h000100) begin n_fail++; $display("FAIL up_1s: got %h want %h", shown0(), 24'h000100); end
    n_checks++; if (sw0.running !== 1'b1 || sw0.done !== 1'b0) begin n_fail++; $display("FAIL up_status: got run=%b done=%b want 1/0", sw0.running, sw0.done); end
    n_checks++; if (shown0() !== to_bcd(m_disp)) begin n_fail++; $display("FAIL up_model: got %h want %h", shown0(), to_bcd(m_disp)); end
  endtask

  task automatic test_wrap();
    do_clear();
    do_load(4'd0, 4'd0, 4'd5, 4'd9, 4'd9, 4'd8);
    do_start();
    tick_clk(5);
    n_checks++; if (shown0() !== 24'h005999) begin n_fail++; $display("FAIL wrap_max_disp: got %h want %h", shown0(), 24'h005999); end
    tick_clk(3);
    n_checks++; if (sw0.wrap !== 1'b1 || sw0.running !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse: got wrap=%b run=%b want 1/1", sw0.wrap, sw0.running); end
    n_checks++; if (sw1.done !== 1'b1 || sw1.running !== 1'b0) begin n_fail++; $display("FAIL sat_done: got done=%b run=%b want 1/0", sw1.done, sw1.running); end
    tick_clk(1);
    n_checks++; if (sw0.wrap !== 1'b0 || shown0() !== 24'h0) begin n_fail++; $display("FAIL wrap_after: got wrap=%b disp=%h want 0/000000", sw0.wrap, shown0()); end
    n_checks++; if (sw1.done !== 1'b0 || shown1() !== 24'h005999) begin n_fail++; $display("FAIL sat_hold: got done=%b disp=%h want 0/005999", sw1.done, shown1()); end
  endtask

  task automatic test_countdown();
    do_clear();
    sw0.dir = 1'b1;
    do_start();
    n_checks++; if (sw0.running !== 1'b0) begin n_fail++; $display("FAIL down_start_at_zero: got run=%b want 0", sw0.running); end
    do_load(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3);
    do_start();
    tick_clk(5);
    n_checks++; if (shown0() !== 24'h000002) begin n_fail++; $display("FAIL down_2: got %h want %h", shown0(), 24'h000002); end
    tick_clk(4);
    n_checks++; if (shown0() !== 24'h000001) begin n_fail++; $display("FAIL down_1: got %h want %h", shown0(), 24'h000001); end
    tick_clk(3);
    n_checks++; if (sw0.done !== 1'b1 || sw0.running !== 1'b0) begin n_fail++; $display("FAIL down_done: got done=%b run=%b want 1/0", sw0.done, sw0.running); end
    tick_clk(1);
    n_checks++; if (sw0.done !== 1'b0 || shown0() !== 24'h0) begin n_fail++; $display("FAIL down_after: got done=%b disp=%h want 0/000000", sw0.done, shown0()); end
    do_start();
    tick_clk(8);
    n_checks++; if (sw0.running !== 1'b0 || sw0.done !== 1'b0 || shown0() !== 24'h0) begin n_fail++; $display("FAIL done_start_ignored: got run=%b done=%b disp=%h", sw0.running, sw0.done, shown0()); end
    sw0.dir = 1'b0;
  endtask

  task automatic test_lap();
    do_clear();
    do_load(4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
    do_start();
    tick_clk(1);
    sw0.lap = 1'b1;
    tick_clk(40);
    n_checks++; if (shown0() !== 24'h001234) begin n_fail++; $display("FAIL lap_frozen: got %h want %h", shown0(), 24'h001234); end
    sw0.lap = 1'b0;
    tick_clk(1);
    n_checks++; if (shown0() !== 24'h001244) begin n_fail++; $display("FAIL lap_release: got %h want %h", shown0(), 24'h001244); end
    sw0.lap = 1'b1;
    do_clear();
    n_checks++; if (shown0() !== 24'h0 || sw0.running !== 1'b0) begin n_fail++; $display("FAIL lap_clear: got disp=%h run=%b want 000000/0", shown0(), sw0.running); end
    sw0.lap = 1'b0;
  endtask

  task automatic test_start_stop_load();
    do_start();
    tick_clk(1);
    sw0.start = 1'b1; sw0.stop = 1'b1;
    @(negedge clk);
    sw0.start = 1'b0; sw0.stop = 1'b0;
    n_checks++; if (sw0.running !== 1'b0) begin n_fail++; $display("FAIL start_stop_pause: got run=%b want 0", sw0.running); end
    do_start();
    tick_clk(2);
    n_checks++; if (shown0() !== 24'h0) begin n_fail++; $display("FAIL resume_early: got %h want %h", shown0(), 24'h0); end
    tick_clk(1);
    n_checks++; if (shown0() !== 24'h000001) begin n_fail++; $display("FAIL resume_presc: got %h want %h", shown0(), 24'h000001); end
    do_load(4'd0, 4'd0, 4'd4, 4'd4, 4'd4, 4'd4);
    tick_clk(1);
    n_checks++; if (shown0() !== 24'h000001 || sw0.running !== 1'b1) begin n_fail++; $display("FAIL load_in_run: got disp=%h run=%b want 000001/1", shown0(), sw0.running); end
    tick_clk(1);
    do_stop();
    do_load(4'd9, 4'd9, 4'd7, 4'd3, 4'd4, 4'd12);
    tick_clk(1);
    n_checks++; if (shown0() !== (MIN_EN ? 24'h995349 : 24'h005349)) begin n_fail++; $display("FAIL load_clamp: got %h want %h", shown0(), MIN_EN ? 24'h995349 : 24'h005349); end
    n_checks++; if (shown0() !== to_bcd(m_disp)) begin n_fail++; $display("FAIL load_model: got %h want %h", shown0(), to_bcd(m_disp)); end
  endtask

  task automatic test_minutes();
`ifdef STOPWATCH_MINUTES_EN
    do_clear();
    do_load(4'd0, 4'd0, 4'd5, 4'd9, 4'd9, 4'd9);
    do_start();
    tick_clk(5);
    n_checks++; if (shown0() !== 24'h010000) begin n_fail++; $display("FAIL min_carry: got %h want %h", shown0(), 24'h010000); end
    do_stop();
    do_load(4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9);
    do_start();
    tick_clk(4);
    n_checks++; if (sw0.wrap !== 1'b1) begin n_fail++; $display("FAIL min_wrap: got %b want 1", sw0.wrap); end
    n_checks++; if (sw1.done !== 1'b1 || sw1.running !== 1'b0) begin n_fail++; $display("FAIL min_sat: got done=%b run=%b want 1/0", sw1.done, sw1.running); end
    tick_clk(1);
    n_checks++; if (shown1() !== 24'h995999 || shown0() !== 24'h0) begin n_fail++; $display("FAIL min_max_disp: got dut1=%h dut0=%h want 995999/000000", shown1(), shown0()); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      sw0.start = ($urandom_range(0, 7) == 0);
      sw0.stop  = ($urandom_range(0, 15) == 0);
      sw0.clear = ($urandom_range(0, 63) == 0);
      sw0.load  = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 63) == 0) sw0.dir = ~sw0.dir;
      if ($urandom_range(0, 31) == 0) sw0.lap = ~sw0.lap;
      if ($urandom_range(0, 3) == 0) begin
        sw0.load_min_tens = 4'd9; sw0.load_min_ones = 4'd9; sw0.load_sec_tens = 4'd5;
        sw0.load_sec_ones = 4'd9; sw0.load_hund_tens = 4'd9;
      end else begin
        sw0.load_min_tens  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 12)) : 4'd0;
        sw0.load_min_ones  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 12)) : 4'd0;
        sw0.load_sec_tens  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 7)) : 4'd0;
        sw0.load_sec_ones  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 12)) : 4'd0;
        sw0.load_hund_tens = 4'($urandom_range(0, 15));
      end
      sw0.load_hund_ones = 4'($urandom_range(0, 15));
      @(negedge clk);
      n_checks++; if (shown0() !== to_bcd(m_disp)) begin n_fail++; $display("FAIL rand_disp cyc %0d: got %h want %h", i, shown0(), to_bcd(m_disp)); end
      n_checks++; if (sw0.running !== (m_state == M_RUN)) begin n_fail++; $display("FAIL rand_running cyc %0d: got %b want %b", i, sw0.running, m_state == M_RUN); end
      n_checks++; if (sw0.done !== m_done) begin n_fail++; $display("FAIL rand_done cyc %0d: got %b want %b", i, sw0.done, m_done); end
      n_checks++; if (sw0.wrap !== m_wrap) begin n_fail++; $display("FAIL rand_wrap cyc %0d: got %b want %b", i, sw0.wrap, m_wrap); end
    end
    rst = 1'b0; sw0.start = 1'b0; sw0.stop = 1'b0; sw0.clear = 1'b0; sw0.load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sw0.start = 1'b0; sw0.stop = 1'b0; sw0.clear = 1'b0; sw0.load = 1'b0;
    sw0.dir = 1'b0; sw0.lap = 1'b0;
    sw0.load_min_tens = 4'd0; sw0.load_min_ones = 4'd0; sw0.load_sec_tens = 4'd0;
    sw0.load_sec_ones = 4'd0; sw0.load_hund_tens = 4'd0; sw0.load_hund_ones = 4'd0;
    @(negedge clk);
    test_reset();
    test_count_up();
    test_wrap();
    test_countdown();
    test_lap();
    test_start_stop_load();
    test_minutes();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stopwatch_timer.md
Name: stopwatch_timer

Overview:
- Parametrised successor to the stopwatch digit counter. Counts in hundredths of a second from a prescaled system clock.
- Counts up or down, with a BCD preload, a run/pause/done state machine, and a lap-hold display that freezes while counting continues.
- Drives the stopwatch display path and raises a done pulse when a countdown expires.

Parameters:
TICK_DIV, 500000, clk cycles per hundredth-second tick (>=1; 500000 at 50 MHz)
WRAP, 1, up-count at max value: 1 = wrap to zero with wrap pulse, 0 = saturate and enter DONE

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  pulse: enter RUN
stop  in  1  pulse: RUN -> PAUSE
clear  in  1  pulse, synchronous: zero count and prescaler, go IDLE
load  in  1  pulse: load preload digits (IDLE/PAUSE/DONE only)
dir  in  1  0 = count up, 1 = count down
lap  in  1  level: 1 holds display outputs, counting continues
load_min_tens, load_min_ones, load_sec_tens, load_sec_ones, load_hund_tens, load_hund_ones  in  4 each  BCD preload
min_tens, min_ones, sec_tens, sec_ones, hund_tens, hund_ones  out  4 each  BCD display digits
running  out  1  1 while in RUN
done  out  1  one-cycle pulse on countdown expiry or up-count saturation
wrap  out  1  one-cycle pulse on up-count wrap

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, prescaler 0, all live and display digits 0, running/done/wrap 0.
- States:
  - IDLE -start-> RUN
  - RUN -stop-> PAUSE
  - PAUSE -start-> RUN
  - RUN -expiry/saturate-> DONE
  - any -clear-> IDLE
  - IDLE/PAUSE/DONE -load-> IDLE
- Start is ignored in DONE. Start is also ignored when dir=1 and the live value is all zero.
- Command priority in one cycle: rst > clear > load > stop > start. Start+stop together = stop. Load in RUN is ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and holds otherwise.
  - tick = RUN && prescaler==TICK_DIV-1; prescaler then returns to 0.
  - clear, load and rst zero the prescaler. PAUSE -> RUN resumes from the held prescaler value.
- Live digits: BCD ripple on tick; no binary count and no divide/modulo.
  - Up: hund_ones 9->0 carries to hund_tens; hund_tens 9->0 carries to sec_ones; sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to minutes (macro) or marks max.
  - Down: mirror borrow chain; sec_tens borrows 0->5.
- Max value: 59.99 without macro, 99:59.99 with it.
  - Up at max, WRAP=1: all digits 0, wrap=1 for the tick cycle, stay RUN.
  - Up at max, WRAP=0: digits hold max, done=1 one cycle, go DONE.
- Down reaching all zero: done=1 on the cycle the zero value is written, go DONE. Digits never underflow.
- dir is sampled per tick; a change mid-run takes effect at the next tick.
- Load clamping: digit >9 loads as 9; sec_tens >5 loads as 5. Minute inputs are ignored without the macro.
- Display outputs:
  - Registered copy of the live digits, 1 clk latency after the live update.
  - lap=1: display holds its current value and the live count keeps counting.
  - lap 1->0: display shows the live value on the next clk.
  - clear and rst force the display to 0 regardless of lap.
- running = (state==RUN), registered with the state.

Optional Feature:
Macro: STOPWATCH_MINUTES_EN.
- Defined: min_ones (0-9) and min_tens (0-9) extend the chain; max is 99:59.99; minute preload digits are honoured.
- Undefined: min_tens/min_ones are tied to 0, preload minute inputs are unused, max is 59.99, and minute carry logic is not synthesised.

Test Plan:
- TICK_DIV=4, rst, start, run 400 clks -> display 01.00 one clk after the 100th tick; running=1; done=0.
- Up, WRAP=1, load 59.98, start, 2 ticks -> live 59.99 then 00.00; wrap=1 for exactly one clk; still RUN.
- dir=1, load 00.03, start, 3 ticks -> 00.02, 00.01, 00.00; done pulse once; state DONE; further start ignored; display stays 00.00.
- Running at 12.34, lap=1 for 40 clks (10 ticks) -> display frozen at 12.34; lap=0 -> display 12.44 one clk later.
- Same cycle start+stop in RUN -> PAUSE. clear while lap=1 -> IDLE with display 00.00. load with sec_tens=7, hund_ones=12 -> loads 5 and 9.
- With STOPWATCH_MINUTES_EN, up from 00:59.99 one tick -> 01:00.00; from 99:59.99 with WRAP=0 -> holds, done pulse, DONE.
